// File: rtl/ddr4_cmd_scheduler.sv
// rtl/ddr4_cmd_scheduler.sv - single-rank DDR4 command sequencer with per-bank row tracking and periodic refresh
// Optional feature macro: CLOSED_PAGE_EN (auto-precharge on every access, rows never left open)
module ddr4_cmd_scheduler #(
  parameter int BG_BITS  = 2,
  parameter int B_BITS   = 2,
  parameter int ROW_BITS = 15,
  parameter int COL_BITS = 10,
  parameter int TRCD     = 4,
  parameter int TRP      = 4,
  parameter int TCL      = 5,
  parameter int TRFC     = 8,
  parameter int TREFI    = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ROW_BITS-1:0] req_row,
  input  logic [COL_BITS-1:0] req_col,
  input  logic [BG_BITS-1:0]  req_bg,
  input  logic [B_BITS-1:0]   req_b,
  output logic                cmd_valid,
  output logic [3:0]          cmd_code,
  output logic [ROW_BITS-1:0] cmd_row,
  output logic [COL_BITS-1:0] cmd_col,
  output logic [BG_BITS-1:0]  cmd_bg,
  output logic [B_BITS-1:0]   cmd_b,
  output logic                done,
  output logic                busy
);

  localparam int BANK_BITS = BG_BITS + B_BITS;
  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int T_A   = (TRCD > TRP) ? TRCD : TRP;
  localparam int T_B   = (T_A > TCL) ? T_A : TCL;
  localparam int T_C   = (T_B > TRFC) ? T_B : TRFC;
  localparam int T_MAX = (T_C > TREFI) ? T_C : TREFI;
  localparam int CW    = $clog2(T_MAX + 1);

  // Wait states hold T-2 so the following issue state lands exactly T cycles after the first command
  localparam logic [CW-1:0] RCD_LOAD  = CW'((TRCD > 1) ? TRCD - 2 : 0);
  localparam logic [CW-1:0] RP_LOAD   = CW'((TRP > 1) ? TRP - 2 : 0);
  localparam logic [CW-1:0] CL_LOAD   = CW'(TCL - 1);
  localparam logic [CW-1:0] RFC_LOAD  = CW'(TRFC - 1);
  localparam logic [CW-1:0] REFI_LAST = CW'(TREFI - 1);

  localparam logic [3:0] CMD_DES  = 4'd0;
  localparam logic [3:0] CMD_ACT  = 4'd1;
  localparam logic [3:0] CMD_PRE  = 4'd2;
  localparam logic [3:0] CMD_REF  = 4'd7;
  localparam logic [3:0] CMD_PREA = 4'd8;
`ifdef CLOSED_PAGE_EN
  localparam logic [3:0] CMD_READ  = 4'd5;
  localparam logic [3:0] CMD_WRITE = 4'd6;
  localparam logic       OPEN_PAGE = 1'b0;
`else
  localparam logic [3:0] CMD_READ  = 4'd3;
  localparam logic [3:0] CMD_WRITE = 4'd4;
  localparam logic       OPEN_PAGE = 1'b1;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_CL, S_PREA, S_REF, S_WAIT_RFC
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         tmr, tmr_n, ref_cnt;
  logic                  ref_pending, rp_to_ref, rp_to_ref_n;
  logic                  cap_write;
  logic [ROW_BITS-1:0]   cap_row;
  logic [COL_BITS-1:0]   cap_col;
  logic [BG_BITS-1:0]    cap_bg;
  logic [B_BITS-1:0]     cap_b;
  logic [NUM_BANKS-1:0]  bank_open;
  logic [ROW_BITS-1:0]   bank_row [NUM_BANKS];
  logic [BANK_BITS-1:0]  req_idx, cap_idx;
  logic                  capture, bank_set, bank_clr, bank_clr_all, ref_issue, rp_clear;
  logic                  cmd_valid_n, done_n;
  logic [3:0]            cmd_code_n;
  logic [ROW_BITS-1:0]   cmd_row_n;
  logic [COL_BITS-1:0]   cmd_col_n;
  logic [BG_BITS-1:0]    cmd_bg_n;
  logic [B_BITS-1:0]     cmd_b_n;

  assign req_idx   = {req_bg, req_b};
  assign cap_idx   = {cap_bg, cap_b};
  assign req_ready = (state == S_IDLE) && !ref_pending;
  assign busy      = (state != S_IDLE);

`ifdef CLOSED_PAGE_EN
  // Auto-precharge starts at the access; hold off ACT/REF until TRP after done
  logic [CW-1:0] rp_guard;
  always_ff @(posedge clock) begin
    if (reset)              rp_guard <= '0;
    else if (done_n)        rp_guard <= CW'(TRP - 1);
    else if (rp_guard != 0) rp_guard <= rp_guard - 1'b1;
  end
  assign rp_clear = (rp_guard == '0);
`else
  assign rp_clear = 1'b1;
`endif

  always_comb begin
    state_n      = state;
    tmr_n        = tmr;
    rp_to_ref_n  = rp_to_ref;
    cmd_valid_n  = 1'b0;
    cmd_code_n   = CMD_DES;
    cmd_row_n    = '0;
    cmd_col_n    = '0;
    cmd_bg_n     = '0;
    cmd_b_n      = '0;
    done_n       = 1'b0;
    capture      = 1'b0;
    bank_set     = 1'b0;
    bank_clr     = 1'b0;
    bank_clr_all = 1'b0;
    ref_issue    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ref_pending) begin
          state_n = (|bank_open) ? S_PREA : S_REF;
        end else if (req_valid) begin
          capture = 1'b1;
          if (!bank_open[req_idx])               state_n = S_ACT;
          else if (bank_row[req_idx] == req_row) state_n = S_RW;
          else                                   state_n = S_PRE;
        end
      end
      S_PRE: begin
        cmd_valid_n = 1'b1;
        cmd_code_n  = CMD_PRE;
        cmd_bg_n    = cap_bg;
        cmd_b_n     = cap_b;
        bank_clr    = 1'b1;
        rp_to_ref_n = 1'b0;
        tmr_n       = RP_LOAD;
        state_n     = (TRP > 1) ? S_WAIT_RP : S_ACT;
      end
      S_PREA: begin
        cmd_valid_n  = 1'b1;
        cmd_code_n   = CMD_PREA;
        bank_clr_all = 1'b1;
        rp_to_ref_n  = 1'b1;
        tmr_n        = RP_LOAD;
        state_n      = (TRP > 1) ? S_WAIT_RP : S_REF;
      end
      S_WAIT_RP: begin
        if (tmr == '0) state_n = rp_to_ref ? S_REF : S_ACT;
        else           tmr_n   = tmr - 1'b1;
      end
      S_ACT: begin
        if (rp_clear) begin
          cmd_valid_n = 1'b1;
          cmd_code_n  = CMD_ACT;
          cmd_row_n   = cap_row;
          cmd_bg_n    = cap_bg;
          cmd_b_n     = cap_b;
          bank_set    = OPEN_PAGE;
          tmr_n       = RCD_LOAD;
          state_n     = (TRCD > 1) ? S_WAIT_RCD : S_RW;
        end
      end
      S_WAIT_RCD: begin
        if (tmr == '0) state_n = S_RW;
        else           tmr_n   = tmr - 1'b1;
      end
      S_RW: begin
        cmd_valid_n = 1'b1;
        cmd_code_n  = cap_write ? CMD_WRITE : CMD_READ;
        cmd_col_n   = cap_col;
        cmd_bg_n    = cap_bg;
        cmd_b_n     = cap_b;
        tmr_n       = CL_LOAD;
        state_n     = S_WAIT_CL;
      end
      S_WAIT_CL: begin
        if (tmr == '0) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      S_REF: begin
        if (rp_clear) begin
          cmd_valid_n  = 1'b1;
          cmd_code_n   = CMD_REF;
          bank_clr_all = 1'b1;
          ref_issue    = 1'b1;
          tmr_n        = RFC_LOAD;
          state_n      = S_WAIT_RFC;
        end
      end
      S_WAIT_RFC: begin
        if (tmr == '0) state_n = S_IDLE;
        else           tmr_n   = tmr - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      tmr         <= '0;
      rp_to_ref   <= 1'b0;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      cap_write   <= 1'b0;
      cap_row     <= '0;
      cap_col     <= '0;
      cap_bg      <= '0;
      cap_b       <= '0;
      bank_open   <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= CMD_DES;
      cmd_row     <= '0;
      cmd_col     <= '0;
      cmd_bg      <= '0;
      cmd_b       <= '0;
      done        <= 1'b0;
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      rp_to_ref <= rp_to_ref_n;
      cmd_valid <= cmd_valid_n;
      cmd_code  <= cmd_code_n;
      cmd_row   <= cmd_row_n;
      cmd_col   <= cmd_col_n;
      cmd_bg    <= cmd_bg_n;
      cmd_b     <= cmd_b_n;
      done      <= done_n;
      if (capture) begin
        cap_write <= req_write;
        cap_row   <= req_row;
        cap_col   <= req_col;
        cap_bg    <= req_bg;
        cap_b     <= req_b;
      end
      if (bank_clr_all)  bank_open          <= '0;
      else if (bank_clr) bank_open[cap_idx] <= 1'b0;
      else if (bank_set) bank_open[cap_idx] <= 1'b1;
      // A wrap during a pending refresh simply keeps it pending; a new wrap outranks a same-cycle REF
      ref_cnt <= (ref_cnt == REFI_LAST) ? '0 : ref_cnt + 1'b1;
      if (ref_cnt == REFI_LAST) ref_pending <= 1'b1;
      else if (ref_issue)       ref_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (bank_set) bank_row[cap_idx] <= cap_row;
  end

endmodule
